// File: rtl/shift_deser.sv
// shift_deser: serial-to-4-bit deserializer with direction select, one-word output buffer and overrun flag.
// Defining PARITY_EN extends each frame to 4 data bits plus 1 even-parity bit and drives perr.
module shift_deser (
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
   input  logic       sen,
   input  logic       start,
   input  logic       dir,
   output logic [3:0] out,
   output logic       valid,
   input  logic       ready,
   output logic       busy,
   output logic       overrun,
   output logic       perr
);
   typedef enum logic {IDLE, RECV} state_t;
   state_t     r_state;
   logic [2:0] r_cnt;
   logic [3:0] r_sr;
   logic       r_dir;
   logic [3:0] r_out;
   logic       r_valid;
   logic       r_ovr;
   logic       r_perr;
   logic [3:0] w_shift;
   logic [3:0] w_word;
   logic       w_par;
   assign w_shift = r_dir ? {sin, r_sr[3:1]} : {r_sr[2:0], sin};
`ifdef PARITY_EN
   localparam logic [2:0] LAST = 3'd4;
   assign w_word = r_sr;
   assign w_par  = ^r_sr ^ sin;
`else
   localparam logic [2:0] LAST = 3'd3;
   assign w_word = w_shift;
   assign w_par  = 1'b0;
`endif
   assign out     = r_out;
   assign valid   = r_valid;
   assign busy    = (r_state == RECV);
   assign overrun = r_ovr;
   assign perr    = r_perr;
   // frame FSM, shift register and single-entry output buffer; completion into a full, unconsumed buffer drops the word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
         r_sr    <= 4'd0;
         r_dir   <= 1'b0;
         r_out   <= 4'd0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
         r_perr  <= 1'b0;
      end else begin
         if (r_valid && ready) r_valid <= 1'b0;
         if (start) begin
            r_state <= RECV;
            r_cnt   <= 3'd0;
            r_sr    <= 4'd0;
            r_dir   <= dir;
         end else if (r_state == RECV && sen) begin
            if (r_cnt == LAST) begin
               r_state <= IDLE;
               r_cnt   <= 3'd0;
               if (!r_valid || ready) begin
                  r_out   <= w_word;
                  r_perr  <= w_par;
                  r_valid <= 1'b1;
               end else begin
                  r_ovr <= 1'b1;
               end
            end else begin
               r_sr  <= w_shift;
               r_cnt <= r_cnt + 3'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: scoreboard bench for shift_deser with a frame-level reference model and random traffic.
module tb_shift_deser;
`ifdef PARITY_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sin = 1'b0, sen = 1'b0, start = 1'b0, dir = 1'b0, ready = 1'b0;
   logic [3:0] out;
   logic       valid, busy, overrun, perr;
   int         n_chk = 0, n_pass = 0;
   logic       mon_en = 1'b0;
   logic       m_busy = 1'b0, m_dir = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
   logic       m_bits[$];
   logic [4:0] sb[$];

   shift_deser dut (
      .clk(clk), .rst(rst), .sin(sin), .sen(sen), .start(start), .dir(dir),
      .out(out), .valid(valid), .ready(ready), .busy(busy), .overrun(overrun), .perr(perr)
   );

   always #5 clk = ~clk;

   function automatic void chk(string n, int a, int e);
      n_chk++;
      if (a == e) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", n, a, e);
   endfunction

   function automatic logic rd(int r);
      return (r == 2) ? 1'($urandom) : 1'(r);
   endfunction

   // frame-level reference: collect bits, build the word arithmetically once the frame is complete
   task automatic model(input logic st, d, s, e, r);
      logic       dlv;
      logic [3:0] w;
      logic       p;
      dlv = 1'b0;
      if (st) begin
         m_busy = 1'b1;
         m_bits.delete();
         m_dir = d;
      end else if (m_busy && e) begin
         m_bits.push_back(s);
         if (m_bits.size() == NB) begin
            w = 4'd0;
            for (int i = 0; i < 4; i++) if (m_bits[i]) w[m_dir ? i : 3 - i] = 1'b1;
`ifdef PARITY_EN
            p = ^w ^ m_bits[4];
`else
            p = 1'b0;
`endif
            m_busy = 1'b0;
            m_bits.delete();
            if (m_valid && !r) m_ovr = 1'b1;
            else begin
               sb.push_back({p, w});
               dlv = 1'b1;
            end
         end
      end
      m_valid = dlv || (m_valid && !r);
   endtask

   task automatic step(input logic st, d, s, e, r);
      start = st; dir = d; sin = s; sen = e; ready = r;
      @(posedge clk);
      model(st, d, s, e, r);
      #1;
   endtask

   task automatic do_reset();
      start = 0; sen = 0; ready = 0; rst = 1'b1;
      #1;
      chk("rst_out", out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_perr", perr, 0);
      m_busy = 0; m_dir = 0; m_valid = 0; m_ovr = 0;
      m_bits.delete();
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   // seq[3] is sent first; dir is randomized between bits to show only the start edge latches it
   task automatic frame(input logic d, input logic [3:0] seq, input logic par, input int gap, input int r, input int rl);
      step(1'b1, d, 1'($urandom), 1'($urandom), rd(r));
      for (int i = 0; i < NB; i++) begin
         repeat (gap) step(1'b0, 1'($urandom), 1'($urandom), 1'b0, rd(r));
         step(1'b0, 1'($urandom), (i < 4) ? seq[3 - i] : par, 1'b1, rd((i == NB - 1) ? rl : r));
      end
   endtask

   task automatic partial(input logic d, input int k);
      step(1'b1, d, 1'($urandom), 1'($urandom), 1'b0);
      for (int i = 0; i < k; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
   endtask

   // monitor: outputs must match the model; a consume pops the scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", busy, m_busy);
         chk("valid", valid, m_valid);
         chk("overrun", overrun, m_ovr);
         if (valid) begin
            chk("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
               chk("out", out, sb[0][3:0]);
               chk("perr", perr, sb[0][4]);
               if (ready) sb.pop_front();
            end
         end
      end
   end

   initial begin
      do_reset();
      frame(1'b0, 4'b1011, 1'b1, 0, 0, 0);
      chk("msb_out", out, 4'b1011);
      chk("msb_valid", valid, 1);
      chk("msb_busy", busy, 0);
      step(0, 0, 0, 0, 1);
      frame(1'b1, 4'b0110, 1'b0, 2, 0, 0);
      chk("lsb_out", out, 4'b0110);
      step(0, 0, 0, 0, 1);
      frame(1'b0, 4'b1011, 1'b1, 0, 0, 0);
      frame(1'b0, 4'b0001, 1'b1, 0, 0, 0);
      chk("ovr_out", out, 4'b1011);
      chk("ovr_flag", overrun, 1);
      step(0, 0, 0, 0, 1);
      chk("ovr_cons_valid", valid, 0);
      chk("ovr_sticky", overrun, 1);
      do_reset();
      frame(1'b0, 4'b1011, 1'b1, 0, 0, 0);
      frame(1'b0, 4'b0001, 1'b1, 0, 0, 1);
      chk("simul_out", out, 4'b0001);
      chk("simul_valid", valid, 1);
      chk("simul_ovr", overrun, 0);
      step(0, 0, 0, 0, 1);
      partial(1'b0, 2);
      frame(1'b0, 4'b1111, 1'b0, 0, 0, 0);
      chk("restart_out", out, 4'b1111);
      step(0, 0, 0, 0, 1);
      partial(1'b0, 3);
      do_reset();
      repeat (4) step(0, 0, 1, 1, 0);
      chk("no_word_after_rst", valid, 0);
`ifdef PARITY_EN
      frame(1'b0, 4'b0110, 1'b0, 0, 0, 0);
      chk("par_ok_perr", perr, 0);
      step(0, 0, 0, 0, 1);
      frame(1'b0, 4'b0110, 1'b1, 0, 0, 0);
      chk("par_bad_perr", perr, 1);
      chk("par_bad_out", out, 4'b0110);
      step(0, 0, 0, 0, 1);
`endif
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 5) == 0) partial(1'($urandom), $urandom_range(0, NB - 1));
         else frame(1'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 2), 2, 2);
         repeat ($urandom_range(0, 2)) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      repeat (3) step(0, 0, 0, 0, 1);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
